// File: rtl/tile_occupancy_map.sv
// tile_occupancy_map: snoops the VGA pixel-plot stream into a COLSxROWS tile colour map
// with an occupied-tile counter and a req/ack query port.
module tile_occupancy_map #(
  parameter int XDIM = 10,
  parameter int YDIM = 10,
  parameter int COLS = 16,
  parameter int ROWS = 12
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       clear,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       req,
  input  logic [3:0] qx,
  input  logic [3:0] qy,
  output logic       ack,
  output logic [2:0] q_colour,
  output logic       q_occ,
  output logic       q_oob,
  output logic       busy,
  output logic [7:0] occ_count
);
  localparam int N = COLS * ROWS;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, occ_q, occ_d;
  logic ack_q, ack_d, q_occ_q, q_occ_d, q_oob_q, q_oob_d;
  logic [2:0] q_colour_q, q_colour_d;
  logic [2:0] mem_q [N];
  logic [7:0] tx, ty, pidx, qidx, waddr;
  logic [2:0] old, wdata, qval;
  logic plot_ok, accept, oob, we, last;
  always_comb begin
    tx = x / 8'(XDIM);
    ty = {1'b0, y} / 8'(YDIM);
    pidx = ty * 8'(COLS) + tx;
    qidx = {4'b0, qy} * 8'(COLS) + {4'b0, qx};
    oob = {1'b0, qx} >= 5'(COLS) || {1'b0, qy} >= 5'(ROWS);
    plot_ok = state_q == IDLE && plot && !clear && x < 8'(COLS * XDIM) && y < 7'(ROWS * YDIM);
    accept = state_q == IDLE && req && !ack_q;
    last = cnt_q == 8'(N - 1);
    // Clamp read addresses so out-of-range coordinates never index past storage.
    old = mem_q[plot_ok ? pidx : 8'd0];
    qval = oob ? 3'd0 : mem_q[oob ? 8'd0 : qidx];
    we = state_q == CLEAR || plot_ok;
    waddr = state_q == CLEAR ? cnt_q : pidx;
    wdata = state_q == CLEAR ? 3'd0 : colour;
    state_d = clear ? CLEAR : (state_q == CLEAR && last) ? IDLE : state_q;
    cnt_d = (state_q == IDLE || clear || last) ? 8'd0 : cnt_q + 8'd1;
    occ_d = (state_q == CLEAR || clear) ? 8'd0 :
            !plot_ok ? occ_q :
            (old == 3'd0 && colour != 3'd0) ? occ_q + 8'd1 :
            (old != 3'd0 && colour == 3'd0) ? occ_q - 8'd1 : occ_q;
    ack_d = accept;
    q_colour_d = accept ? qval : q_colour_q;
    q_occ_d = accept ? qval != 3'd0 : q_occ_q;
    q_oob_d = accept ? oob : q_oob_q;
  end
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q <= CLEAR;
      cnt_q <= 8'd0;
      occ_q <= 8'd0;
      ack_q <= 1'b0;
      q_colour_q <= 3'd0;
      q_occ_q <= 1'b0;
      q_oob_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      occ_q <= occ_d;
      ack_q <= ack_d;
      q_colour_q <= q_colour_d;
      q_occ_q <= q_occ_d;
      q_oob_q <= q_oob_d;
    end
  end
  always_ff @(posedge CLOCK_50)
    if (Resetn && we) mem_q[waddr] <= wdata;
  assign ack = ack_q;
  assign q_colour = q_colour_q;
  assign q_occ = q_occ_q;
  assign q_oob = q_oob_q;
  assign busy = state_q == CLEAR;
  assign occ_count = occ_q;
endmodule

// File: doc/tile_occupancy_map.md
# tile_occupancy_map

Tile occupancy map for the snake game. It snoops the pixel-plot stream that the drawing FSMs send to `vga_adapter` (x, y, colour, plot) and folds it into a 16x12 map of 10x10-pixel tiles. The game logic can then read the map through a req/ack query port for self-collision and apple-hit checks, without reading the framebuffer back. It sits beside `vga_adapter` on the same x/y/colour/plot nets and is the read-back end of that write interface.

## Interface
- `XDIM`, 10: tile width in pixels
- `YDIM`, 10: tile height in pixels
- `COLS`, 16: tiles per row (160/XDIM)
- `ROWS`, 12: tiles per column (120/YDIM)
- `CLOCK_50  input  1`: system clock; all logic on the rising edge
- `Resetn  input  1`: reset, synchronous, active-low; clock CLOCK_50
- `clear  input  1`: one-cycle pulse; starts a sweep that empties the whole map
- `plot  input  1`: pixel write strobe, same net as the vga_adapter plot input
- `x  input  8`: pixel column, 0..159
- `y  input  7`: pixel row, 0..119
- `colour  input  3`: pixel colour; 3'b000 means empty/erased
- `req  input  1`: query request; held high until `ack`
- `qx  input  4`: query tile column
- `qy  input  4`: query tile row
- `ack  output  1`: one-cycle pulse; query result is valid in this cycle
- `q_colour  output  3`: stored colour of the queried tile
- `q_occ  output  1`: queried tile is non-empty (q_colour != 0)
- `q_oob  output  1`: query coordinates are out of range
- `busy  output  1`: a clear sweep is in progress
- `occ_count  output  8`: number of non-empty tiles, 0..192

## Operation
- Storage is COLS*ROWS = 192 entries of 3 bits each, addressed as idx = ty*COLS + tx (0..191).
- **Plot path**
  - tx = floor(x/XDIM) and ty = floor(y/YDIM). Exact results are required for x<160 and y<120; a multiply-shift such as (x*205)>>11 is acceptable.
  - On `plot`=1 with x<160, y<120 and `busy`=0, the entry at idx is written with `colour`.
  - A plot with x>=160 or y>=120 is ignored. Any plot while `busy`=1 is ignored.
  - Repeated plots of the same colour to the same tile are idempotent.
- **occ_count**
  - A write that changes an entry from 0 to non-zero increments it.
  - A write that changes an entry from non-zero to 0 decrements it.
  - Any other write leaves it unchanged. It never wraps.
- **FSM**, two states: CLEAR and IDLE.
  - CLEAR: a sweep counter runs 0..191 and writes 0 to one entry per cycle. `busy`=1. On the cycle that writes entry 191, the next state is IDLE. `occ_count` is forced to 0 for the whole sweep.
  - IDLE: `busy`=0. Plots and queries are serviced. A `clear`=1 moves the FSM to CLEAR, with the counter restarting at 0.
  - `clear` while already in CLEAR restarts the sweep at 0.
- **Query**
  - A query is accepted on an edge where `req`=1, `busy`=0 and `ack`=0.
  - On the next cycle, `ack`=1 and `q_*` reflect the entry as it stood before any write in the acceptance cycle (read-before-write).
  - If qx>=COLS or qy>=ROWS: `q_oob`=1, `q_colour`=0, `q_occ`=0.
  - `q_*` hold their values until the next ack.
  - A `req` held during `busy` waits and is accepted on the first idle cycle.
  - Maximum throughput is one query every 2 cycles.

## Timing
- **Reset** (`Resetn`=0 at an edge) gives, on the next cycle: state=CLEAR, sweep counter=0, `busy`=1, `ack`=0, `q_colour`=0, `q_occ`=0, `q_oob`=0, `occ_count`=0.
  - Storage is zeroed by the sweep, not by reset.
- **Sweep length**: `busy` is high for exactly 192 cycles after reset release or after `clear` is sampled. Plot/query service starts on the following cycle.
- **Reset mid-sweep or mid-query**: the sweep restarts from 0 and any pending `ack` is cancelled.
- **Plot latency**: 1 cycle. A write at edge N is visible to a query accepted at edge N+1 or later.
- **Plot and query in the same cycle**:
  - Same tile: the query returns the old value.
  - Different tiles: both take effect.
- **clear and plot in the same IDLE cycle**: `clear` wins and the plot is dropped.
- **Index bounds**: the sweep counter and idx never exceed 191, and no write lands outside storage.

## Test plan
- **Reset then query**: reset, wait 192 cycles, query (3,2) -> `busy` falls exactly 192 cycles after release; ack one cycle after acceptance; q_colour=0, q_occ=0, occ_count=0.
- **Full-tile draw**: plot a 10x10 block at x=30..39, y=30..39 with colour 3'b100 -> query (3,3) gives q_colour=4, q_occ=1, occ_count=1. Erase it with colour 0 -> q_occ=0, occ_count=0.
- **Boundary tiles**:
  - Plot (159,119) colour 7 -> tile (15,11) reads 7.
  - Plot (160,5) -> ignored.
  - Query (16,0) -> q_oob=1, q_colour=0.
  - Plot x=9 maps to tx=0 and x=10 maps to tx=1.
- **Read-before-write**: plot (50,60) colour 2 and accept a query for (5,6) in the same cycle -> query returns 0; the next query returns 2.
- **Clear mid-game**: occupy 4 tiles, pulse `clear` -> busy=1 for 192 cycles, occ_count=0, all 4 tiles read 0. A req held during busy is acked on the cycle after the first idle acceptance edge.
- **Reset mid-sweep**: assert `Resetn`=0 at sweep count 100 -> sweep restarts and `busy` stays high 192 cycles after release.
